// File: rtl/prio_arb_pkg.sv
// Shared types and constants for the registered priority / round-robin arbiter.
package prio_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/prio_pick.sv
// Combinational masked picker: fixed (highest index) or round-robin from a start pointer.
module prio_pick
    import prio_arb_pkg::*;
#(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   mask,
    input  logic [IDW-1:0] start,
    input  logic           mode,
    output logic [N-1:0]   win,
    output logic [IDW-1:0] win_id,
    output logic           any
);

    logic [N-1:0] eff;
    assign eff = req & ~mask;

    // Candidates are visited lowest-priority first so the last hit is the winner.
    always_comb begin
        logic [IDW-1:0] cand;
        win    = '0;
        win_id = '0;
        any    = |eff;
        cand   = '0;
        if (mode == MODE_RR) begin
            for (int k = int'(N) - 1; k >= 0; k--) begin
                cand = IDW'((int'(start) + int'(N) - k) % int'(N));
                if (eff[cand]) begin
                    win_id = cand;
                end
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                cand = IDW'(i);
                if (eff[cand]) begin
                    win_id = cand;
                end
            end
        end
        if (any) begin
            win[win_id] = 1'b1;
        end
    end

endmodule

// File: rtl/prio_arbiter_rr.sv
// Registered N-input arbiter with hold limit; fixed-priority or round-robin selection.
module prio_arbiter_rr
    import prio_arb_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned IDW      = $clog2(N),
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           mode,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           valid
);

    localparam int unsigned    HCW      = $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

    state_e         state_q, state_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] id_q, id_d;
    logic           valid_q, valid_d;

    logic [N-1:0]   p_win, x_win;
    logic [IDW-1:0] p_id, x_id;
    logic           p_any, x_any;

    prio_pick #(.N(N), .IDW(IDW)) u_pick_norm (
        .req    (req),
        .mask   ({N{1'b0}}),
        .start  (ptr_q),
        .mode   (mode),
        .win    (p_win),
        .win_id (p_id),
        .any    (p_any)
    );

    // Exclusion picker masks the current holder for hold-limit releases.
    prio_pick #(.N(N), .IDW(IDW)) u_pick_excl (
        .req    (req),
        .mask   (gnt_q),
        .start  (ptr_q),
        .mode   (mode),
        .win    (x_win),
        .win_id (x_id),
        .any    (x_any)
    );

    always_comb begin
        logic           new_grant;
        logic [N-1:0]   nw;
        logic [IDW-1:0] nid;
        state_d   = state_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        valid_d   = valid_q;
        new_grant = 1'b0;
        nw        = p_win;
        nid       = p_id;

        unique case (state_q)
            IDLE: begin
                new_grant = p_any;
            end
            GRANT: begin
                if (req[id_q] && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end else if (!req[id_q]) begin
                    if (p_any) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        id_d    = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
                    // Sole requester at the limit is simply re-granted without a gap.
                    new_grant = 1'b1;
                    nw        = x_any ? x_win : gnt_q;
                    nid       = x_any ? x_id : id_q;
                end
            end
        endcase

        if (new_grant) begin
            state_d = GRANT;
            gnt_d   = nw;
            id_d    = nid;
            valid_d = 1'b1;
            hold_d  = HCW'(1);
            ptr_d   = (nid == '0) ? LAST_ID : nid - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            ptr_q   <= LAST_ID;
            gnt_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = id_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// Self-checking bench: vector table, hand-written corner sequences and randomized model comparison.
module tb_prio_arbiter_rr;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       mode = 1'b0;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       valid_a, valid_b;

    always #5 clk = ~clk;

    prio_arbiter_rr #(.N(4), .MAX_HOLD(3)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .mode   (mode),
        .gnt    (gnt_a),
        .gnt_id (id_a),
        .valid  (valid_a)
    );

    prio_arbiter_rr #(.N(4), .MAX_HOLD(1)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .mode   (mode),
        .gnt    (gnt_b),
        .gnt_id (id_b),
        .valid  (valid_b)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: holder, hold count and round-robin pointer as plain integers.
    int m_valid[2];
    int m_id[2];
    int m_cnt[2];
    int m_ptr[2];
    int m_hold[2] = '{3, 1};

    function automatic bit bit_set(logic [3:0] r, int i);
        return ((r >> i) & 4'd1) != 4'd0;
    endfunction

    function automatic int arb(logic [3:0] r, int excl, logic md, int ptr);
        if (md == 1'b0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (bit_set(r, i) && i != excl) return i;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (ptr - k + N) % N;
                if (bit_set(r, c) && c != excl) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_id[k]    = 0;
            m_cnt[k]   = 0;
            m_ptr[k]   = N - 1;
        end
    endtask

    task automatic model_grant(int k, int w);
        m_valid[k] = 1;
        m_id[k]    = w;
        m_cnt[k]   = 1;
        m_ptr[k]   = (w == 0) ? N - 1 : w - 1;
    endtask

    task automatic model_step(int k, logic [3:0] r, logic md);
        int w;
        if (m_valid[k] == 0) begin
            w = arb(r, -1, md, m_ptr[k]);
            if (w >= 0) model_grant(k, w);
        end else if (bit_set(r, m_id[k]) && m_cnt[k] < m_hold[k]) begin
            m_cnt[k]++;
        end else if (!bit_set(r, m_id[k])) begin
            w = arb(r, -1, md, m_ptr[k]);
            if (w >= 0) begin
                model_grant(k, w);
            end else begin
                m_valid[k] = 0;
                m_id[k]    = 0;
                m_cnt[k]   = 0;
            end
        end else begin
            w = arb(r, m_id[k], md, m_ptr[k]);
            if (w < 0) w = m_id[k];
            model_grant(k, w);
        end
    endtask

    function automatic int exp_gnt(int k);
        return (m_valid[k] != 0) ? (1 << m_id[k]) : 0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0, req, mode);
        model_step(1, req, mode);
        #1;
    endtask

    task automatic check_dut(string tag);
        check({tag, " a.gnt"}, int'(gnt_a), exp_gnt(0));
        check({tag, " a.id"}, int'(id_a), m_id[0]);
        check({tag, " a.valid"}, int'(valid_a), m_valid[0]);
        check({tag, " b.gnt"}, int'(gnt_b), exp_gnt(1));
        check({tag, " b.id"}, int'(id_b), m_id[1]);
        check({tag, " b.valid"}, int'(valid_b), m_valid[1]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       mode;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
    } vec_t;

    vec_t tbl[$];

    task automatic add(logic [3:0] r, logic md, logic [3:0] g, logic [1:0] id, logic v);
        vec_t e;
        e.req = r; e.mode = md; e.gnt = g; e.id = id; e.valid = v;
        tbl.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        int rr_seq[6] = '{3, 2, 1, 0, 3, 2};

        repeat (5) add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1);
        add(4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1);
        add(4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        repeat (10) add(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        repeat (3) add(4'b1100, 1'b0, 4'b1000, 2'd3, 1'b1);
        repeat (3) add(4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1);
        add(4'b1100, 1'b0, 4'b1000, 2'd3, 1'b1);
        add(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1);
        add(4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);

        do_reset();
        check("reset a.gnt", int'(gnt_a), 0);
        check("reset a.id", int'(id_a), 0);
        check("reset a.valid", int'(valid_a), 0);
        check("reset b.valid", int'(valid_b), 0);

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            mode = tbl[i].mode;
            tick();
            check($sformatf("tbl%0d gnt", i), int'(gnt_a), int'(tbl[i].gnt));
            check($sformatf("tbl%0d id", i), int'(id_a), int'(tbl[i].id));
            check($sformatf("tbl%0d valid", i), int'(valid_a), int'(tbl[i].valid));
        end

        // Round-robin with a one-cycle hold limit rotates every cycle and wraps.
        do_reset();
        mode = 1'b1;
        req  = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr1 id%0d", i), int'(id_b), rr_seq[i]);
            check($sformatf("rr1 valid%0d", i), int'(valid_b), 1);
        end

        // Asynchronous reset mid-grant, sampled well before the next rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async a.gnt", int'(gnt_a), 0);
        check("async a.id", int'(id_a), 0);
        check("async a.valid", int'(valid_a), 0);
        check("async b.gnt", int'(gnt_b), 0);
        check("async b.valid", int'(valid_b), 0);
        req = 4'b0000;
        do_reset();

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            tick();
            check_dut($sformatf("rand%0d", c));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
